// File: rtl/axil_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write path (AW/W/B) between S_COUNT masters.
// One write in flight at a time; the grant is held until the B handshake completes.
module axil_wr_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]           s_axil_awprot,
  input  logic [S_COUNT-1:0]             s_axil_awvalid,
  output logic [S_COUNT-1:0]             s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic [S_COUNT-1:0]             s_axil_wvalid,
  output logic [S_COUNT-1:0]             s_axil_wready,
  output logic [S_COUNT*2-1:0]           s_axil_bresp,
  output logic [S_COUNT-1:0]             s_axil_bvalid,
  input  logic [S_COUNT-1:0]             s_axil_bready,
  output logic [ADDR_WIDTH-1:0]          m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [DATA_WIDTH-1:0]          m_axil_wdata,
  output logic [STRB_WIDTH-1:0]          m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready
);

  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_last;
  logic            r_aw_done;
  logic            r_w_done;

  logic [GW-1:0]   w_pick;
  logic            w_any;
  logic            w_in_xfer;
  logic            w_in_resp;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_hs;

  // Circular scan from r_last+1: first pass covers indices above r_last,
  // second pass wraps around to indices at or below it.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (!w_any && s_axil_awvalid[i] && (GW'(i) > r_last)) begin
        w_any  = 1'b1;
        w_pick = GW'(i);
      end
    end
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (!w_any && s_axil_awvalid[i] && (GW'(i) <= r_last)) begin
        w_any  = 1'b1;
        w_pick = GW'(i);
      end
    end
  end

  assign w_in_xfer = (r_state == XFER);
  assign w_in_resp = (r_state == RESP);

  assign m_axil_awaddr  = s_axil_awaddr[32'(r_g)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_awprot  = s_axil_awprot[32'(r_g)*3 +: 3];
  assign m_axil_wdata   = s_axil_wdata[32'(r_g)*DATA_WIDTH +: DATA_WIDTH];
  assign m_axil_wstrb   = s_axil_wstrb[32'(r_g)*STRB_WIDTH +: STRB_WIDTH];

  assign m_axil_awvalid = w_in_xfer & s_axil_awvalid[r_g] & ~r_aw_done;
  assign m_axil_wvalid  = w_in_xfer & s_axil_wvalid[r_g] & ~r_w_done;
  assign m_axil_bready  = w_in_resp & s_axil_bready[r_g];

  assign w_aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_w_hs  = m_axil_wvalid & m_axil_wready;
  assign w_b_hs  = w_in_resp & m_axil_bvalid & s_axil_bready[r_g];

  assign s_axil_bresp = {S_COUNT{m_axil_bresp}};

  always_comb begin
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    if (w_in_xfer) begin
      s_axil_awready[r_g] = m_axil_awready & ~r_aw_done;
      s_axil_wready[r_g]  = m_axil_wready & ~r_w_done;
    end
    if (w_in_resp) begin
      s_axil_bvalid[r_g] = m_axil_bvalid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_g       <= '0;
      r_last    <= GW'(S_COUNT - 1);
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g     <= w_pick;
            r_state <= XFER;
          end
        end
        XFER: begin
          // Either channel may finish first or both in the same cycle.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state   <= RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        RESP: begin
          if (w_b_hs) begin
            r_last  <= r_g;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Bench for axil_wr_arbiter: directed scenarios plus randomized requests checked
// against a transaction-level round-robin model.
module tb_axil_wr_arbiter;

  localparam int S  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic [S*AW-1:0] s_awaddr;
  logic [S*3-1:0]  s_awprot;
  logic [S-1:0]    s_awvalid, s_awready;
  logic [S*DW-1:0] s_wdata;
  logic [S*SW-1:0] s_wstrb;
  logic [S-1:0]    s_wvalid, s_wready;
  logic [S*2-1:0]  s_bresp;
  logic [S-1:0]    s_bvalid, s_bready;
  logic [AW-1:0]   m_awaddr;
  logic [2:0]      m_awprot;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;

  axil_wr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
    .s_axil_awready(s_awready), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
    .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_bresp(s_bresp),
    .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
    .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int last_m;
  logic [AW-1:0] e_addr [S];
  logic [DW-1:0] e_data [S];
  logic [SW-1:0] e_strb [S];
  logic [2:0]    e_prot [S];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Reference arbitration rule: first requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [S-1:0] req, input int last);
    for (int k = 1; k <= S; k++) begin
      if (req[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    e_addr[m] = a;
    e_data[m] = d;
    e_strb[m] = SW'($urandom_range(1, (1 << SW) - 1));
    e_prot[m] = 3'($urandom_range(0, 7));
    s_awaddr[m*AW +: AW] = a;
    s_awprot[m*3 +: 3]   = e_prot[m];
    s_wdata[m*DW +: DW]  = d;
    s_wstrb[m*SW +: SW]  = e_strb[m];
    s_awvalid[m] = 1'b1;
    s_wvalid[m]  = 1'b1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_m_awvalid"}, m_awvalid, 0);
    chk({tag, "_m_wvalid"},  m_wvalid, 0);
    chk({tag, "_m_bready"},  m_bready, 0);
    chk({tag, "_s_awready"}, s_awready, 0);
    chk({tag, "_s_wready"},  s_wready, 0);
    chk({tag, "_s_bvalid"},  s_bvalid, 0);
  endtask

  // Runs one complete write from IDLE with the given slave-side latencies.
  task automatic txn(input int aw_lat, input int w_lat, input int b_lat, input int br_lat,
                     input logic [1:0] resp, output int g);
    logic [S-1:0] oh;
    int  c;
    bit  awd, wd, exp_av, exp_wv, aw_hs, w_hs, b_hs;
    g = rr_pick(s_awvalid, last_m);
    if (g < 0) begin
      n_chk++; n_err++;
      $error("FAIL no_request observed=none expected=a pending master");
      return;
    end
    oh = S'(1) << g;
    #1;
    chk("idle_m_awvalid", m_awvalid, 0);
    chk("idle_s_awready", s_awready, 0);
    tick;
    awd = 0; wd = 0; c = 0;
    while (!(awd && wd)) begin
      if (c > 40) begin
        n_chk++; n_err++;
        $error("FAIL xfer_timeout observed=%0d cycles expected=%0d", c, (aw_lat > w_lat ? aw_lat : w_lat) + 1);
        break;
      end
      m_awready = (c >= aw_lat);
      m_wready  = (c >= w_lat);
      #1;
      exp_av = s_awvalid[g] && !awd;
      exp_wv = s_wvalid[g] && !wd;
      chk("m_awvalid", m_awvalid, exp_av);
      chk("m_wvalid",  m_wvalid, exp_wv);
      chk("s_awready", s_awready, (m_awready && !awd) ? oh : '0);
      chk("s_wready",  s_wready, (m_wready && !wd) ? oh : '0);
      chk("xfer_s_bvalid", s_bvalid, 0);
      chk("xfer_m_bready", m_bready, 0);
      if (exp_av) begin
        chk("m_awaddr", m_awaddr, e_addr[g]);
        chk("m_awprot", m_awprot, e_prot[g]);
      end
      if (exp_wv) begin
        chk("m_wdata", m_wdata, e_data[g]);
        chk("m_wstrb", m_wstrb, e_strb[g]);
      end
      aw_hs = exp_av && m_awready;
      w_hs  = exp_wv && m_wready;
      tick;
      if (aw_hs) begin awd = 1; s_awvalid[g] = 1'b0; end
      if (w_hs)  begin wd = 1;  s_wvalid[g]  = 1'b0; end
      c++;
    end
    chk("xfer_cycles", c, (aw_lat > w_lat ? aw_lat : w_lat) + 1);
    m_awready = 1'b0;
    m_wready  = 1'b0;
    c = 0;
    forever begin
      if (c > 40) begin
        n_chk++; n_err++;
        $error("FAIL resp_timeout observed=%0d cycles expected=%0d", c, b_lat > br_lat ? b_lat : br_lat);
        break;
      end
      m_bvalid    = (c >= b_lat);
      m_bresp     = resp;
      s_bready[g] = (c >= br_lat);
      #1;
      chk("s_bvalid", s_bvalid, m_bvalid ? oh : '0);
      chk("m_bready", m_bready, s_bready[g]);
      chk("resp_m_awvalid", m_awvalid, 0);
      chk("resp_s_awready", s_awready, 0);
      if (m_bvalid) chk("s_bresp", s_bresp[g*2 +: 2], resp);
      b_hs = m_bvalid && s_bready[g];
      tick;
      if (b_hs) begin
        chk("b_cycles", c, b_lat > br_lat ? b_lat : br_lat);
        break;
      end
      c++;
    end
    m_bvalid    = 1'b0;
    s_bready[g] = 1'b0;
    last_m      = g;
    #1;
    quiet("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int cnt [S];
    logic [S-1:0] oh;
    rst = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    last_m = S - 1;
    for (int m = 0; m < S; m++) cnt[m] = 0;
    tick;
    tick;
    #1;
    quiet("reset");
    rst = 1'b0;
    tick;

    // Round robin between masters 0 and 1, four writes each.
    req(0, 32'h0000_0100, 32'hA000_0000);
    req(1, 32'h0000_0200, 32'hB000_0000);
    for (int i = 0; i < 8; i++) begin
      txn(0, 0, 0, 0, 2'b00, g);
      chk("rr_order", g, i % 2);
      cnt[g]++;
      if (g >= 0 && g < 2 && cnt[g] < 4) req(g, 32'(256 * (g + 1) + 4 * cnt[g]), $urandom);
    end

    // Single write from master 0.
    req(0, 32'h10, 32'hDEADBEEF);
    txn(0, 0, 0, 0, 2'b00, g);
    chk("single_grant", g, 0);

    // W before AW on master 1; AW accepted two cycles late.
    req(1, 32'h0000_1234, 32'h1111_2222);
    s_awvalid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      quiet("w_only");
      tick;
    end
    s_awvalid[1] = 1'b1;
    txn(2, 0, 0, 0, 2'b00, g);
    chk("w_first_grant", g, 1);

    // W backpressure for five cycles.
    req(2, 32'h0000_2000, 32'h2222_3333);
    txn(0, 5, 0, 0, 2'b00, g);
    chk("wstall_grant", g, 2);

    // B stall with SLVERR; master holds bready low for four cycles.
    req(3, 32'h0000_3000, 32'h3333_4444);
    txn(0, 0, 0, 4, 2'b10, g);
    chk("bstall_grant", g, 3);

    // Async reset during a W stall; master 0 must win afterwards.
    req(1, 32'h0000_5100, 32'h5151_5151);
    req(0, 32'h0000_5000, 32'h5050_5050);
    g = rr_pick(s_awvalid, last_m);
    oh = S'(1) << g;
    m_awready = 1'b1;
    m_wready  = 1'b0;
    tick;
    #1;
    chk("pre_rst_s_awready", s_awready, oh);
    chk("pre_rst_m_wvalid", m_wvalid, 1);
    rst = 1'b1;
    #1;
    quiet("async_rst");
    m_awready = 1'b0;
    tick;
    rst = 1'b0;
    last_m = S - 1;
    txn(0, 0, 0, 0, 2'b00, g);
    chk("rst_first_grant", g, 0);
    txn(1, 1, 1, 0, 2'b01, g);
    chk("rst_second_grant", g, 1);

    // Randomized requests and slave latencies.
    for (int it = 0; it < 30; it++) begin
      for (int m = 0; m < S; m++) begin
        if (!s_awvalid[m] && $urandom_range(0, 1) == 1) req(m, $urandom, $urandom);
      end
      if (s_awvalid == '0) begin
        g = $urandom_range(0, S - 1);
        req(g, $urandom, $urandom);
      end
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 2'($urandom_range(0, 3)), g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
